stopwatch_timebase: RTL and testbench
=====================================

// Module: stopwatch_timebase
// PURPOSE
//   Front end of the stopwatch datapath. Divides clk down to 1 s, counts seconds 0..59 and
//   runs the start/stop/clear control FSM. Drives the downstream 0..99 minutes counter:
//   min_tick -> its sec_tick, run_en -> its enable, mins_rst_n -> its rst_n.
// PARAMETERS
//   TICKS_PER_SEC  100_000_000  clk cycles per second; legal range >= 2 (bench uses 4)
//   PRE_W          $clog2(TICKS_PER_SEC)  prescaler width; localparam, not overridable
// PORTS
//   clk         in   1  clock, all logic on posedge
//   rst_n       in   1  synchronous reset, active low
//   start       in   1  1-cycle pulse: start or resume counting
//   stop        in   1  1-cycle pulse: pause counting
//   clear       in   1  1-cycle pulse: zero everything, return to IDLE
//   running     out  1  1 while FSM is in RUNNING
//   seconds     out  6  elapsed seconds, 0..59
//   min_tick    out  1  1-cycle pulse on each 59->0 seconds wrap; feeds minutes sec_tick
//   run_en      out  1  enable for the minutes counter
//   mins_rst_n  out  1  sync active-low reset for the minutes counter
// BEHAVIOUR
//   Reset (rst_n=0 at posedge):
//     - state=IDLE; prescaler=0; seconds=0
//     - running=0, min_tick=0, run_en=0, mins_rst_n=0
//     - mins_rst_n is registered: it rises on the first edge with rst_n=1
//   FSM states: IDLE, RUNNING, PAUSED. Command priority: clear > stop > start.
//     - IDLE:    start & !stop -> RUNNING. Prescaler and seconds are held at 0.
//     - RUNNING: stop -> PAUSED. start is ignored.
//     - PAUSED:  start & !stop -> RUNNING. Prescaler and seconds hold their values,
//                so the partial second is preserved.
//     - Any state, clear: next state IDLE, prescaler=0, seconds=0, min_tick=0,
//       mins_rst_n=0 for exactly one cycle.
//   Counting happens only on edges where the current state is RUNNING and clear=0:
//     - prescaler == TICKS_PER_SEC-1: prescaler->0 and seconds increments.
//     - Otherwise prescaler increments.
//     - Seconds wrap: when seconds==59 at terminal count, seconds->0 and min_tick=1 on
//       the same edge, so min_tick is high in the cycle where seconds first reads 0.
//   min_tick timing:
//     - Registered; high for exactly 1 cycle; never high on two consecutive cycles.
//     - The first second completes TICKS_PER_SEC cycles after the edge that enters RUNNING.
//   Stop/tick coincidence:
//     - A stop arriving on a terminal-count edge does not suppress that edge's increment
//       or min_tick; the stop takes effect from the next cycle.
//   Clear/tick coincidence:
//     - clear wins. No increment and no min_tick occur.
//   run_en = (state==RUNNING) | min_tick, registered alongside min_tick.
//     - The downstream counter never drops a min_tick that coincides with a stop.
//   Downstream latency:
//     - The minutes counter updates one edge after min_tick, i.e. it lags the 59->0
//       seconds wrap by one cycle.
//   Other rules:
//     - start/stop/clear are already synchronous single-cycle pulses; no debounce here.
//     - Held levels re-evaluate every cycle and have no extra effect.
//     - seconds never exceeds 59.
//     - Prescaler arithmetic is PRE_W-bit unsigned; it never exceeds TICKS_PER_SEC-1.
// TESTING (TICKS_PER_SEC=4)
//   1. Reset: hold rst_n=0 for 2 cycles, then release.
//      -> seconds=0, running=0, min_tick=0, run_en=0, mins_rst_n=0 during reset;
//         mins_rst_n=1 from the first edge after release.
//   2. start, then run 240 cycles.
//      -> seconds steps every 4 cycles and reads 59 at cycle 236;
//      -> at cycle 240 seconds=0 with a single min_tick pulse (run_en=1);
//      -> the minutes output reads 1 one cycle later.
//   3. stop with prescaler=2, wait 10 cycles, then start.
//      -> seconds is frozen while PAUSED;
//      -> it increments 2 cycles after re-entering RUNNING.
//   4. stop on the terminal edge of seconds=59.
//      -> seconds=0, min_tick=1, run_en=1, state=PAUSED;
//      -> the next cycle has run_en=0 and min_tick=0.
//   5. clear while running at seconds=37.
//      -> next cycle: seconds=0, state=IDLE, running=0;
//      -> mins_rst_n=0 for exactly one cycle.
//   6. start & stop asserted together in IDLE -> state stays IDLE.
//      start & stop together in PAUSED -> state stays PAUSED.

Source files
------------

// File: rtl/stopwatch_timebase.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stopwatch_timebase                                           |
// | Description : Stopwatch front end. Divides clk down to a 1 s tick, counts  |
// |               seconds 0..59 and runs the IDLE/RUNNING/PAUSED control FSM.  |
// |               Drives the downstream 0..99 minutes counter.                 |
// | Ports       : clk          - clock, all logic on rising edge               |
// |               rst_n        - synchronous reset, active low                 |
// |               start_i      - 1-cycle pulse, start or resume counting       |
// |               stop_i       - 1-cycle pulse, pause counting                 |
// |               clear_i      - 1-cycle pulse, zero everything, go to IDLE    |
// |               running_o    - high while the FSM is in RUNNING              |
// |               seconds_o    - elapsed seconds, 0..59                        |
// |               min_tick_o   - 1-cycle pulse on each 59->0 seconds wrap      |
// |               run_en_o     - enable for the minutes counter                |
// |               mins_rst_n_o - synchronous active-low reset, minutes counter |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module stopwatch_timebase #(
   parameter int unsigned TICKS_PER_SEC = 100_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_i,
   input  logic       stop_i,
   input  logic       clear_i,
   output logic       running_o,
   output logic [5:0] seconds_o,
   output logic       min_tick_o,
   output logic       run_en_o,
   output logic       mins_rst_n_o
);

   localparam int unsigned      PRE_W     = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PRE_W-1:0] c_pre_max = PRE_W'(TICKS_PER_SEC - 1);
   localparam logic [PRE_W-1:0] c_pre_one = PRE_W'(1);
   localparam logic [5:0]       c_sec_max = 6'd59;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUNNING = 2'd1,
      ST_PAUSED  = 2'd2
   } state_t;

   state_t           state_q,      state_d;
   logic [PRE_W-1:0] pre_q,        pre_d;
   logic [5:0]       sec_q,        sec_d;
   logic             min_tick_q,   min_tick_d;
   logic             run_en_q,     run_en_d;
   logic             mins_rst_n_q, mins_rst_n_d;

   logic             w_resume;
   logic             w_terminal;

   // A resume needs start without a simultaneous stop (stop outranks start).
   assign w_resume   = start_i & ~stop_i;
   assign w_terminal = (pre_q == c_pre_max);

   // ------------------------------------------------------------------------
   // Next-state / datapath
   // ------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      pre_d        = pre_q;
      sec_d        = sec_q;
      min_tick_d   = 1'b0;
      mins_rst_n_d = ~clear_i;

      if (clear_i) begin
         state_d = ST_IDLE;
         pre_d   = '0;
         sec_d   = 6'd0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               pre_d = '0;
               sec_d = 6'd0;
               if (w_resume) begin
                  state_d = ST_RUNNING;
               end
            end

            ST_RUNNING: begin
               // Counting is decided by the current state, so a stop on a
               // terminal-count edge still takes that edge's increment/tick.
               if (stop_i) begin
                  state_d = ST_PAUSED;
               end
               if (w_terminal) begin
                  pre_d = '0;
                  if (sec_q >= c_sec_max) begin
                     sec_d      = 6'd0;
                     min_tick_d = 1'b1;
                  end else begin
                     sec_d = sec_q + 6'd1;
                  end
               end else begin
                  pre_d = pre_q + c_pre_one;
               end
            end

            ST_PAUSED: begin
               // Prescaler and seconds hold, preserving the partial second.
               if (w_resume) begin
                  state_d = ST_RUNNING;
               end
            end

            default: begin
               state_d = ST_IDLE;
               pre_d   = '0;
               sec_d   = 6'd0;
            end
         endcase
      end

      // Registered with min_tick so a tick coinciding with a stop still
      // sees the enable high in the same cycle downstream.
      run_en_d = (state_d == ST_RUNNING) | min_tick_d;
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pre_q        <= '0;
         sec_q        <= 6'd0;
         min_tick_q   <= 1'b0;
         run_en_q     <= 1'b0;
         mins_rst_n_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pre_q        <= pre_d;
         sec_q        <= sec_d;
         min_tick_q   <= min_tick_d;
         run_en_q     <= run_en_d;
         mins_rst_n_q <= mins_rst_n_d;
      end
   end

   assign running_o    = (state_q == ST_RUNNING);
   assign seconds_o    = sec_q;
   assign min_tick_o   = min_tick_q;
   assign run_en_o     = run_en_q;
   assign mins_rst_n_o = mins_rst_n_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_timebase.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_stopwatch_timebase                                        |
// | Description : Self-checking bench for stopwatch_timebase with             |
// |               TICKS_PER_SEC=4, directed scenarios plus random commands     |
// |               checked against an elapsed-cycle reference model.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_stopwatch_timebase;

   localparam int T        = 4;
   localparam int M_IDLE   = 0;
   localparam int M_RUN    = 1;
   localparam int M_PAUSE  = 2;

   logic       clk;
   logic       rst_n;
   logic       start_i, stop_i, clear_i;
   logic       running_o;
   logic [5:0] seconds_o;
   logic       min_tick_o;
   logic       run_en_o;
   logic       mins_rst_n_o;

   int tests_run;
   int fails;

   // Reference model: total cycles spent counting since the last clear/reset.
   longint m_el;
   int     m_st;
   bit     m_mt, m_ren, m_mrn;

   // Downstream minutes counter as the integration would wire it.
   logic [6:0] mins;

   stopwatch_timebase #(.TICKS_PER_SEC(T)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start_i),
      .stop_i       (stop_i),
      .clear_i      (clear_i),
      .running_o    (running_o),
      .seconds_o    (seconds_o),
      .min_tick_o   (min_tick_o),
      .run_en_o     (run_en_o),
      .mins_rst_n_o (mins_rst_n_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (!mins_rst_n_o)                mins <= 7'd0;
      else if (run_en_o && min_tick_o)  mins <= (mins == 7'd99) ? 7'd0 : mins + 7'd1;
   end

   function automatic logic [5:0] m_sec();
      return 6'((m_el / T) % 60);
   endfunction

   // Drive one cycle of commands, advance the model, settle past the edge.
   task automatic tick(input logic s, input logic p, input logic c);
      @(negedge clk);
      start_i = s; stop_i = p; clear_i = c;
      @(posedge clk);
      if (!rst_n) begin
         m_st = M_IDLE; m_el = 0; m_mt = 0; m_ren = 0; m_mrn = 0;
      end else begin
         m_mrn = !c;
         m_mt  = 0;
         if (c) begin
            m_st = M_IDLE;
            m_el = 0;
         end else begin
            if (m_st == M_RUN) begin
               m_el++;
               if (m_el % (60 * T) == 0) m_mt = 1;
            end
            if (m_st == M_RUN && p)            m_st = M_PAUSE;
            else if (m_st != M_RUN && s && !p) m_st = M_RUN;
         end
         m_ren = (m_st == M_RUN) || m_mt;
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(0, 0, 0);
      tick(0, 0, 0);
      tests_run++;
      if ({running_o, seconds_o, min_tick_o, run_en_o, mins_rst_n_o} !== 10'd0) begin
         fails++;
         $display("FAIL reset_state: got run=%b sec=%0d mt=%b ren=%b mrn=%b, want all 0",
                  running_o, seconds_o, min_tick_o, run_en_o, mins_rst_n_o);
      end
      rst_n = 1'b1;
      tick(0, 0, 0);
      tests_run++;
      if (mins_rst_n_o !== 1'b1 || running_o !== 1'b0 || seconds_o !== 6'd0) begin
         fails++;
         $display("FAIL reset_release: got mrn=%b run=%b sec=%0d, want mrn=1 run=0 sec=0",
                  mins_rst_n_o, running_o, seconds_o);
      end
   endtask

   task automatic test_full_minute();
      int ticks_seen;
      ticks_seen = 0;
      tick(1, 0, 0);
      tests_run++;
      if (running_o !== 1'b1 || seconds_o !== 6'd0) begin
         fails++;
         $display("FAIL start_enter: got run=%b sec=%0d, want run=1 sec=0", running_o, seconds_o);
      end
      for (int i = 1; i <= 240; i++) begin
         tick(0, 0, 0);
         if (min_tick_o === 1'b1) ticks_seen++;
         tests_run++;
         if (seconds_o !== 6'((i / 4) % 60)) begin
            fails++;
            $display("FAIL minute_sec cyc %0d: got %0d want %0d", i, seconds_o, (i / 4) % 60);
         end
         if (i == 236) begin
            tests_run++;
            if (seconds_o !== 6'd59) begin
               fails++;
               $display("FAIL sec59_at_236: got %0d want 59", seconds_o);
            end
         end
      end
      tests_run++;
      if (seconds_o !== 6'd0 || min_tick_o !== 1'b1 || run_en_o !== 1'b1 || ticks_seen != 1) begin
         fails++;
         $display("FAIL wrap_240: got sec=%0d mt=%b ren=%b ticks=%0d, want 0 1 1 1",
                  seconds_o, min_tick_o, run_en_o, ticks_seen);
      end
      tests_run++;
      if (mins !== 7'd0) begin
         fails++;
         $display("FAIL mins_before_lag: got %0d want 0", mins);
      end
      tick(0, 0, 0);
      tests_run++;
      if (mins !== 7'd1 || min_tick_o !== 1'b0) begin
         fails++;
         $display("FAIL mins_after_lag: got mins=%0d mt=%b want mins=1 mt=0", mins, min_tick_o);
      end
   endtask

   task automatic test_pause_resume();
      // 241 counted cycles so far; this stop edge leaves the prescaler at 2.
      tick(0, 1, 0);
      for (int i = 0; i < 10; i++) begin
         tick(0, 0, 0);
         tests_run++;
         if (seconds_o !== 6'd0 || running_o !== 1'b0) begin
            fails++;
            $display("FAIL paused_frozen %0d: got sec=%0d run=%b want sec=0 run=0", i, seconds_o, running_o);
         end
      end
      tick(1, 0, 0);
      tick(0, 0, 0);
      tests_run++;
      if (seconds_o !== 6'd0 || running_o !== 1'b1) begin
         fails++;
         $display("FAIL resume_plus1: got sec=%0d run=%b want sec=0 run=1", seconds_o, running_o);
      end
      tick(0, 0, 0);
      tests_run++;
      if (seconds_o !== 6'd1) begin
         fails++;
         $display("FAIL resume_plus2: got sec=%0d want 1", seconds_o);
      end
   endtask

   task automatic test_stop_on_wrap();
      int budget;
      budget = 0;
      while (!(m_st == M_RUN && (m_el % (60 * T)) == (60 * T - 1)) && budget < 400) begin
         tick(m_st != M_RUN, 0, 0);
         budget++;
      end
      tests_run++;
      if (budget >= 400) begin
         fails++;
         $display("FAIL wrap_setup_timeout: got budget %0d want < 400", budget);
      end
      tick(0, 1, 0);
      tests_run++;
      if (seconds_o !== 6'd0 || min_tick_o !== 1'b1 || run_en_o !== 1'b1 || running_o !== 1'b0) begin
         fails++;
         $display("FAIL stop_on_wrap: got sec=%0d mt=%b ren=%b run=%b want 0 1 1 0",
                  seconds_o, min_tick_o, run_en_o, running_o);
      end
      tick(0, 0, 0);
      tests_run++;
      if (min_tick_o !== 1'b0 || run_en_o !== 1'b0 || running_o !== 1'b0 || seconds_o !== 6'd0) begin
         fails++;
         $display("FAIL after_stop_wrap: got mt=%b ren=%b run=%b sec=%0d want 0 0 0 0",
                  min_tick_o, run_en_o, running_o, seconds_o);
      end
   endtask

   task automatic test_clear();
      int budget;
      budget = 0;
      tick(1, 0, 0);
      while (m_sec() != 6'd37 && budget < 400) begin
         tick(0, 0, 0);
         budget++;
      end
      tests_run++;
      if (seconds_o !== 6'd37) begin
         fails++;
         $display("FAIL clear_setup: got sec=%0d want 37", seconds_o);
      end
      tick(0, 0, 1);
      tests_run++;
      if (seconds_o !== 6'd0 || running_o !== 1'b0 || mins_rst_n_o !== 1'b0 || min_tick_o !== 1'b0) begin
         fails++;
         $display("FAIL clear_edge: got sec=%0d run=%b mrn=%b mt=%b want 0 0 0 0",
                  seconds_o, running_o, mins_rst_n_o, min_tick_o);
      end
      tick(0, 0, 0);
      tests_run++;
      if (mins_rst_n_o !== 1'b1 || mins !== 7'd0 || running_o !== 1'b0 || seconds_o !== 6'd0) begin
         fails++;
         $display("FAIL clear_after: got mrn=%b mins=%0d run=%b sec=%0d want 1 0 0 0",
                  mins_rst_n_o, mins, running_o, seconds_o);
      end
   endtask

   task automatic test_start_stop_together();
      tick(1, 1, 0);
      tick(0, 0, 0);
      tests_run++;
      if (running_o !== 1'b0 || seconds_o !== 6'd0) begin
         fails++;
         $display("FAIL idle_start_stop: got run=%b sec=%0d want 0 0", running_o, seconds_o);
      end
      tick(1, 0, 0);
      for (int i = 0; i < 6; i++) tick(0, 0, 0);
      tick(0, 1, 0);
      tick(1, 1, 0);
      tick(0, 0, 0);
      tick(0, 0, 0);
      tests_run++;
      if (running_o !== 1'b0 || seconds_o !== 6'd1) begin
         fails++;
         $display("FAIL paused_start_stop: got run=%b sec=%0d want 0 1", running_o, seconds_o);
      end
   endtask

   task automatic test_random();
      logic [9:0] exp_v, obs_v;
      logic       prev_mt;
      logic       s, p, c;
      prev_mt = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 599) != 0);
         s = ($urandom_range(0, 19) == 0);
         p = ($urandom_range(0, 39) == 0);
         c = ($urandom_range(0, 249) == 0);
         tick(s, p, c);
         exp_v = {m_st == M_RUN, m_sec(), m_mt, m_ren, m_mrn};
         obs_v = {running_o, seconds_o, min_tick_o, run_en_o, mins_rst_n_o};
         tests_run++;
         if (obs_v !== exp_v) begin
            fails++;
            $display("FAIL random cyc %0d: got {run,sec,mt,ren,mrn}=%b want %b", i, obs_v, exp_v);
         end
         tests_run++;
         if ((prev_mt && min_tick_o) || seconds_o > 6'd59) begin
            fails++;
            $display("FAIL random_invariant cyc %0d: got prev_mt=%b mt=%b sec=%0d want no back-to-back tick, sec<=59",
                     i, prev_mt, min_tick_o, seconds_o);
         end
         prev_mt = min_tick_o;
      end
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got time limit reached, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tests_run = 0;
      fails     = 0;
      rst_n     = 1'b0;
      start_i   = 1'b0;
      stop_i    = 1'b0;
      clear_i   = 1'b0;
      test_reset();
      test_full_minute();
      test_pause_resume();
      test_stop_on_wrap();
      test_clear();
      test_start_stop_together();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
`default_nettype wire
